// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: boot/run/halt FSM, redirects, trap entry/return, misaligned-target trap.
// Define PC_GEN_PERF_CNT_EN to add saturating seq/redirect/stall counters.
module pc_gen #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0]  TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned      CNT_W        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            is_branch,
  input  logic            is_jump,
  input  logic            is_jalr,
  input  logic            is_trap,
  input  logic            is_mret,
  input  logic            halt_req,
  input  logic            resume,
  input  logic [XLEN-1:0] immed,
  input  logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] epc,
  output logic            misaligned,
  output logic [XLEN-1:0] bad_addr,
  output logic            halted
`ifdef PC_GEN_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] seq_cnt,
  output logic [CNT_W-1:0] redir_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t                  r_state, w_state_nxt;
  logic [XLEN-1:0]         r_pc, r_epc, r_bad_addr;
  logic                    r_misaligned;
  logic [XLEN-1:0]         w_pc_nxt, w_epc_nxt, w_bad_nxt;
  logic                    w_mis_nxt;
  logic                    w_advance;
  logic                    w_redirect;
  logic signed [XLEN-1:0]  w_immed_s;
  logic [XLEN-1:0]         w_br_tgt, w_jalr_sum, w_jalr_tgt, w_target;

  assign w_immed_s  = signed'(immed);
  assign w_br_tgt   = unsigned'(signed'(r_pc) + w_immed_s);
  assign w_jalr_sum = unsigned'(signed'(rs1_data) + w_immed_s);
  assign w_jalr_tgt = {w_jalr_sum[XLEN-1:1], 1'b0};
  assign w_target   = is_jalr ? w_jalr_tgt : w_br_tgt;
  assign w_redirect = is_jalr | is_jump | is_branch;
  assign w_advance  = (r_state == RUN) && fetch_ready && !stall;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_epc_nxt   = r_epc;
    w_bad_nxt   = r_bad_addr;
    w_mis_nxt   = 1'b0;
    case (r_state)
      BOOT: w_state_nxt = RUN;
      RUN: begin
        if (w_advance) begin
          if (halt_req) w_state_nxt = HALTED;
          if (is_trap) begin
            w_epc_nxt = r_pc;
            w_pc_nxt  = TRAP_VECTOR;
          end else if (is_mret) begin
            w_pc_nxt = r_epc;
          end else if (w_redirect) begin
            // A misaligned redirect is taken as a trap and the bad target is kept for the handler.
            if (w_target[1:0] != 2'b00) begin
              w_epc_nxt = r_pc;
              w_bad_nxt = w_target;
              w_pc_nxt  = TRAP_VECTOR;
              w_mis_nxt = 1'b1;
            end else begin
              w_pc_nxt = w_target;
            end
          end else begin
            w_pc_nxt = r_pc + XLEN'(4);
          end
        end
      end
      HALTED: if (resume) w_state_nxt = RUN;
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= BOOT;
      r_pc         <= RESET_VECTOR;
      r_epc        <= '0;
      r_bad_addr   <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_epc        <= w_epc_nxt;
      r_bad_addr   <= w_bad_nxt;
      r_misaligned <= w_mis_nxt;
    end
  end

  assign pc         = r_pc;
  assign pc_plus4   = r_pc + XLEN'(4);
  assign pc_valid   = (r_state == RUN);
  assign halted     = (r_state == HALTED);
  assign epc        = r_epc;
  assign bad_addr   = r_bad_addr;
  assign misaligned = r_misaligned;

`ifdef PC_GEN_PERF_CNT_EN
  logic [CNT_W-1:0] r_seq_cnt, r_redir_cnt, r_stall_cnt;
  logic             w_cnt_seq, w_cnt_redir, w_cnt_stall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_cnt_redir = w_advance && (is_trap || is_mret || w_redirect);
  assign w_cnt_seq   = w_advance && !(is_trap || is_mret || w_redirect);
  assign w_cnt_stall = (r_state == RUN) && !w_advance;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seq_cnt   <= '0;
      r_redir_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_cnt_seq)   r_seq_cnt   <= sat_inc(r_seq_cnt);
      if (w_cnt_redir) r_redir_cnt <= sat_inc(r_redir_cnt);
      if (w_cnt_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign seq_cnt   = r_seq_cnt;
  assign redir_cnt = r_redir_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: sequential fetch, stall, redirects, misaligned trap, trap/mret, halt, reset, wrap.
// Counter checks are compiled in when PC_GEN_PERF_CNT_EN is defined.
module tb_pc_gen;
  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  logic            clk = 1'b0;
  logic            rst_n, stall, fetch_ready;
  logic            is_branch, is_jump, is_jalr, is_trap, is_mret;
  logic            halt_req, resume;
  logic [XLEN-1:0] immed, rs1_data;
  logic [XLEN-1:0] pc, pc_plus4, epc, bad_addr;
  logic            pc_valid, misaligned, halted;
`ifdef PC_GEN_PERF_CNT_EN
  logic [CNT_W-1:0] seq_cnt, redir_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(XLEN), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .fetch_ready(fetch_ready),
    .is_branch(is_branch), .is_jump(is_jump), .is_jalr(is_jalr),
    .is_trap(is_trap), .is_mret(is_mret), .halt_req(halt_req), .resume(resume),
    .immed(immed), .rs1_data(rs1_data), .pc(pc), .pc_valid(pc_valid),
    .pc_plus4(pc_plus4), .epc(epc), .misaligned(misaligned),
    .bad_addr(bad_addr), .halted(halted)
`ifdef PC_GEN_PERF_CNT_EN
    , .seq_cnt(seq_cnt), .redir_cnt(redir_cnt), .stall_cnt(stall_cnt)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_redir();
    is_branch = 1'b0; is_jump = 1'b0; is_jalr = 1'b0;
    is_trap = 1'b0; is_mret = 1'b0; halt_req = 1'b0; resume = 1'b0;
    immed = '0; rs1_data = '0;
  endtask

  initial begin
    clr_redir();
    rst_n = 1'b0; stall = 1'b0; fetch_ready = 1'b1;

    // reset and sequential fetch
    cycle();
    check_val("rst_pc", pc, 32'h0);
    check_val("rst_valid", pc_valid, 1'b0);
    check_val("rst_halted", halted, 1'b0);
    check_val("rst_epc", epc, 32'h0);
    check_val("rst_bad", bad_addr, 32'h0);
    check_val("rst_mis", misaligned, 1'b0);
    rst_n = 1'b1;
    cycle();
    check_val("boot_pc", pc, 32'h0);
    check_val("boot_valid", pc_valid, 1'b1);
    cycle();
    check_val("seq_pc4", pc, 32'h4);
    cycle();
    check_val("seq_pc8", pc, 32'h8);
    check_val("plus4", pc_plus4, 32'hC);

    // jump to 0x20, stall twice (redirect dropped while stalled), then branch -8
    is_jump = 1'b1; immed = 32'h18;
    cycle(); clr_redir();
    check_val("jump_pc", pc, 32'h20);
    stall = 1'b1; is_branch = 1'b1; immed = 32'h40;
    cycle(); clr_redir();
    check_val("stall1_pc", pc, 32'h20);
    cycle();
    check_val("stall2_pc", pc, 32'h20);
    stall = 1'b0; is_branch = 1'b1; immed = 32'hFFFF_FFF8;
    cycle(); clr_redir();
    check_val("br_neg_pc", pc, 32'h18);

    // jalr aligned, then misaligned target
    is_jalr = 1'b1; rs1_data = 32'h101; immed = 32'h3;
    cycle();
    check_val("jalr_pc", pc, 32'h104);
    check_val("jalr_mis", misaligned, 1'b0);
    immed = 32'h1;
    cycle(); clr_redir();
    check_val("mis_pc", pc, 32'h100);
    check_val("mis_pulse", misaligned, 1'b1);
    check_val("mis_bad", bad_addr, 32'h102);
    check_val("mis_epc", epc, 32'h104);
    cycle();
    check_val("mis_clear", misaligned, 1'b0);
    check_val("mis_next_pc", pc, 32'h104);
    check_val("bad_held", bad_addr, 32'h102);
    is_branch = 1'b1; immed = 32'h2;
    cycle(); clr_redir();
    check_val("br_mis_pc", pc, 32'h100);
    check_val("br_mis_bad", bad_addr, 32'h106);
    check_val("br_mis_pulse", misaligned, 1'b1);

    // trap at 0x40, mret at 0x108
    is_jalr = 1'b1; rs1_data = 32'h40;
    cycle(); clr_redir();
    check_val("to40_pc", pc, 32'h40);
    is_trap = 1'b1;
    cycle(); clr_redir();
    check_val("trap_pc", pc, 32'h100);
    check_val("trap_epc", epc, 32'h40);
    cycle(); cycle();
    check_val("pre_mret_pc", pc, 32'h108);
    is_mret = 1'b1;
    cycle(); clr_redir();
    check_val("mret_pc", pc, 32'h40);
    check_val("mret_epc", epc, 32'h40);

    // trap beats jump, with halt in the same advance
    is_trap = 1'b1; is_jump = 1'b1; immed = 32'h10; halt_req = 1'b1;
    cycle(); clr_redir();
    check_val("prio_pc", pc, 32'h100);
    check_val("prio_epc", epc, 32'h40);
    check_val("halt_on", halted, 1'b1);
    check_val("halt_valid", pc_valid, 1'b0);
    is_jump = 1'b1; immed = 32'h10;
    cycle(); cycle(); clr_redir();
    check_val("halt_frozen", pc, 32'h100);
    check_val("halt_still", halted, 1'b1);
    resume = 1'b1;
    cycle(); clr_redir();
    check_val("resume_halted", halted, 1'b0);
    check_val("resume_valid", pc_valid, 1'b1);
    check_val("resume_pc", pc, 32'h100);
    cycle();
    check_val("post_resume_pc", pc, 32'h104);
    halt_req = 1'b1;
    cycle(); clr_redir();
    check_val("halt2_pc", pc, 32'h108);
    check_val("halt2_on", halted, 1'b1);

    // reset while halted and stalled
    stall = 1'b1; rst_n = 1'b0;
    cycle();
    check_val("rst_h_pc", pc, 32'h0);
    check_val("rst_h_halted", halted, 1'b0);
    check_val("rst_h_valid", pc_valid, 1'b0);
    check_val("rst_h_epc", epc, 32'h0);
    check_val("rst_h_bad", bad_addr, 32'h0);
    stall = 1'b0; rst_n = 1'b1;
    cycle();
    check_val("rst_h_boot", pc_valid, 1'b1);

    // wrap-around and fetch_ready low
    is_jalr = 1'b1; rs1_data = 32'hFFFF_FFF8; immed = 32'h4;
    cycle(); clr_redir();
    check_val("wrap_top", pc, 32'hFFFF_FFFC);
    check_val("wrap_plus4", pc_plus4, 32'h0);
    cycle();
    check_val("wrap_pc", pc, 32'h0);
    fetch_ready = 1'b0; is_jump = 1'b1; immed = 32'h40;
    cycle(); clr_redir();
    check_val("nordy_hold", pc, 32'h0);
    fetch_ready = 1'b1;

    // counters: 3 sequential, 1 branch, 2 stalls after fresh reset
    rst_n = 1'b0;
    cycle();
`ifdef PC_GEN_PERF_CNT_EN
    check_val("cnt_rst_seq", seq_cnt, '0);
    check_val("cnt_rst_redir", redir_cnt, '0);
    check_val("cnt_rst_stall", stall_cnt, '0);
`endif
    rst_n = 1'b1;
    cycle();
    cycle(); cycle(); cycle();
    check_val("cnt_seq_pc", pc, 32'hC);
    is_branch = 1'b1; immed = 32'h10;
    cycle(); clr_redir();
    check_val("cnt_br_pc", pc, 32'h1C);
    stall = 1'b1;
    cycle(); cycle();
    stall = 1'b0;
    check_val("cnt_stall_pc", pc, 32'h1C);
`ifdef PC_GEN_PERF_CNT_EN
    check_val("cnt_seq", seq_cnt, 32'd3);
    check_val("cnt_redir", redir_cnt, 32'd1);
    check_val("cnt_stall", stall_cnt, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
